// File: rtl/uart_frame_pkg.sv
// Framing constants and scheduler states shared by the UART TX frame scheduler and the RX command parser.
package uart_frame_pkg;

   localparam logic [7:0] SOF0 = 8'h53;
   localparam logic [7:0] SOF1 = 8'h54;
   localparam logic [7:0] EOF0 = 8'h45;
   localparam logic [7:0] EOF1 = 8'h4E;
   localparam logic [7:0] EOF2 = 8'h44;

   // 'S','T', id byte, then 'E','N','D' around the payload
   localparam int FRAME_OVERHEAD = 6;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT,
      DONE
   } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: combinational search from the pointer wrapping upward; the pointer moves to winner+1 when
// a win is taken. No backpressure of its own; the caller qualifies wins with enable/advance.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               enable,
   input  logic               advance,
   output logic [NUM_REQ-1:0] winner,
   output logic [PW-1:0]      winner_idx,
   output logic               found
);

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW:0]   cand;

   always_comb begin
      winner     = '0;
      winner_idx = '0;
      found      = 1'b0;
      cand       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, ptr_q} + (PW+1)'(k);
         if (cand >= (PW+1)'(NUM_REQ)) begin
            cand = cand - (PW+1)'(NUM_REQ);
         end
         if (enable && !found && req[cand[PW-1:0]]) begin
            found      = 1'b1;
            winner_idx = cand[PW-1:0];
         end
      end
      if (found) begin
         winner[winner_idx] = 1'b1;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance && found) begin
         ptr_d = (winner_idx == PW'(NUM_REQ - 1)) ? '0 : winner_idx + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/uart_tx_frame_sched.sv
// Shares one UART TX byte engine among NUM_REQ requesters, one framed message per grant (S T id payload E N D).
// One byte in flight: DV waits for TX idle, next byte 1 cycle after TX done; enable gates only new grants.
module uart_tx_frame_sched
   import uart_frame_pkg::*;
#(
   parameter int NUM_REQ       = 2,
   parameter int PAYLOAD_BYTES = 4,
   parameter int IDW           = 3
) (
   input  logic                               i_Clock,
   input  logic                               i_Rst_n,
   input  logic                               i_Enable,
   input  logic [NUM_REQ-1:0]                 i_Req,
   input  logic [NUM_REQ*PAYLOAD_BYTES*8-1:0] i_Payload,
   output logic [NUM_REQ-1:0]                 o_Grant,
   output logic                               o_Busy,
   output logic                               o_TX_DV,
   output logic [7:0]                         o_TX_Byte,
   input  logic                               i_TX_Active,
   input  logic                               i_TX_Done,
   output logic                               o_Frame_Done,
   output logic [IDW-1:0]                     o_Last_Id
);

   localparam int FRAME_LEN = PAYLOAD_BYTES + FRAME_OVERHEAD;
   localparam int CW        = $clog2(FRAME_LEN);
   localparam int PLW       = PAYLOAD_BYTES * 8;
   localparam int PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_e               state_q, state_d;
   logic [CW-1:0]        idx_q, idx_d;
   logic [PLW-1:0]       payload_q, payload_d;
   logic [IDW-1:0]       id_q, id_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic                 busy_q, busy_d;
   logic                 tx_dv_q, tx_dv_d;
   logic [7:0]           tx_byte_q, tx_byte_d;
   logic                 frame_done_q, frame_done_d;
   logic [IDW-1:0]       last_id_q, last_id_d;

   logic [NUM_REQ-1:0]   arb_winner;
   logic [PW-1:0]        arb_idx;
   logic                 arb_found;
   logic [CW-1:0]        pbyte_sel;
   logic [7:0]           cur_byte;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PW      (PW)
   ) u_arb (
      .clk        (i_Clock),
      .rst_n      (i_Rst_n),
      .req        (i_Req),
      .enable     (i_Enable && (state_q == IDLE)),
      .advance    (state_q == IDLE),
      .winner     (arb_winner),
      .winner_idx (arb_idx),
      .found      (arb_found)
   );

   // Byte at the current frame position; payload occupies idx 3 .. PAYLOAD_BYTES+2
   always_comb begin
      pbyte_sel = idx_q - CW'(3);
      cur_byte  = 8'h00;
      if (idx_q == CW'(0)) begin
         cur_byte = SOF0;
      end else if (idx_q == CW'(1)) begin
         cur_byte = SOF1;
      end else if (idx_q == CW'(2)) begin
         cur_byte = 8'(id_q);
      end else if (idx_q < CW'(PAYLOAD_BYTES + 3)) begin
         cur_byte = payload_q[{pbyte_sel, 3'b000} +: 8];
      end else if (idx_q == CW'(PAYLOAD_BYTES + 3)) begin
         cur_byte = EOF0;
      end else if (idx_q == CW'(PAYLOAD_BYTES + 4)) begin
         cur_byte = EOF1;
      end else begin
         cur_byte = EOF2;
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      payload_d    = payload_q;
      id_d         = id_q;
      grant_d      = '0;
      busy_d       = busy_q;
      tx_dv_d      = 1'b0;
      tx_byte_d    = tx_byte_q;
      frame_done_d = 1'b0;
      last_id_d    = last_id_q;
      case (state_q)
         IDLE: begin
            if (arb_found) begin
               grant_d   = arb_winner;
               payload_d = i_Payload[int'(arb_idx)*PLW +: PLW];
               id_d      = IDW'(arb_idx);
               busy_d    = 1'b1;
               state_d   = SEND;
            end
         end
         SEND: begin
            if (!i_TX_Active) begin
               tx_dv_d   = 1'b1;
               tx_byte_d = cur_byte;
               state_d   = WAIT;
            end
         end
         WAIT: begin
            if (i_TX_Done) begin
               if (idx_q == CW'(FRAME_LEN - 1)) begin
                  frame_done_d = 1'b1;
                  last_id_d    = id_q;
                  busy_d       = 1'b0;
                  idx_d        = '0;
                  state_d      = DONE;
               end else begin
                  idx_d   = idx_q + CW'(1);
                  state_d = SEND;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         payload_q    <= '0;
         id_q         <= '0;
         grant_q      <= '0;
         busy_q       <= 1'b0;
         tx_dv_q      <= 1'b0;
         tx_byte_q    <= 8'h00;
         frame_done_q <= 1'b0;
         last_id_q    <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         payload_q    <= payload_d;
         id_q         <= id_d;
         grant_q      <= grant_d;
         busy_q       <= busy_d;
         tx_dv_q      <= tx_dv_d;
         tx_byte_q    <= tx_byte_d;
         frame_done_q <= frame_done_d;
         last_id_q    <= last_id_d;
      end
   end

   assign o_Grant      = grant_q;
   assign o_Busy       = busy_q;
   assign o_TX_DV      = tx_dv_q;
   assign o_TX_Byte    = tx_byte_q;
   assign o_Frame_Done = frame_done_q;
   assign o_Last_Id    = last_id_q;

endmodule

// File: doc/uart_tx_frame_sched.md
Name: uart_tx_frame_sched

Overview:
Round-robin scheduler that shares one byte-wide UART transmitter between NUM_REQ requesters. Each granted requester sends one framed message: 'S','T', requester id, PAYLOAD_BYTES payload bytes, then 'E','N','D'. This is the same framing the RX command parser accepts, so the host side can reuse its decoder. The block sits between the marker/status producers and the UART TX byte engine, and is gated by the RX-decoded streaming-enable flag.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
PAYLOAD_BYTES, 4, payload bytes per frame (1..16); byte 0 is sent first
IDW, 3, width of the requester-id field; the id byte is zero-extended from IDW bits

Ports:
i_Clock  in  1  system clock
i_Rst_n  in  1  asynchronous active-low reset
i_Enable  in  1  streaming enable (from RX flag); gates new grants only
i_Req  in  NUM_REQ  level request per requester; held until granted
i_Payload  in  NUM_REQ*PAYLOAD_BYTES*8  payloads; requester k at [k*PB*8 +: PB*8], byte j at [j*8 +: 8] within it
o_Grant  out  NUM_REQ  one-hot, 1-cycle pulse when the winner's payload is latched
o_Busy  out  1  high from grant until frame complete
o_TX_DV  out  1  1-cycle strobe to the UART TX engine
o_TX_Byte  out  8  byte to send; valid with o_TX_DV
i_TX_Active  in  1  TX engine is shifting a byte
i_TX_Done  in  1  1-cycle pulse when the TX stop bit completes
o_Frame_Done  out  1  1-cycle pulse after the 'D' byte's i_TX_Done
o_Last_Id  out  IDW  id of the most recently completed frame

Behaviour:
- Reset (async): all outputs 0; state IDLE; round-robin pointer = 0; byte counter = 0; payload latch = 0.
- Arbitration: in IDLE with i_Enable=1 and |i_Req, choose the first set request starting at the pointer and wrapping upward.
- Grant cycle: on the choosing edge, latch the winner's payload and id, pulse o_Grant, set o_Busy, and go to SEND. The pointer becomes winner+1, wrapping to 0 after NUM_REQ-1.
- Enable timing: i_Enable falling mid-frame does not abort the frame; the current frame always completes.
- SEND: o_TX_DV=1 for exactly one cycle with o_TX_Byte = frame[idx]. This requires i_TX_Active=0. If it is 1, stay in SEND with DV low until it drops. Then go to WAIT.
- WAIT: hold until i_TX_Done. If idx = FRAME_LEN-1, go to DONE; otherwise idx+1 and go to SEND. The gap between i_TX_Done and the next DV is exactly 1 cycle.
- Frame layout: FRAME_LEN = PAYLOAD_BYTES+6. idx 0='S'(0x53), 1='T'(0x54), 2={0,id}, 3..PB+2 = payload bytes 0..PB-1, PB+3='E'(0x45), PB+4='N'(0x4E), PB+5='D'(0x44).
- DONE: 1 cycle. Pulse o_Frame_Done, update o_Last_Id, clear o_Busy and idx, return to IDLE. A new grant can occur on the next edge, giving back-to-back frames with a 1-cycle IDLE gap.
- Ignored inputs: i_TX_Done seen outside WAIT is ignored. Request changes during a frame are ignored because the payload is already latched.
- Simultaneous requests: strict round-robin. With all requesters asserting continuously, each gets exactly one frame per NUM_REQ frames.
- Request withdrawal: a request dropped before grant is simply not served; no error is flagged.
- Counter width: idx is clog2(PAYLOAD_BYTES+6) bits and never exceeds FRAME_LEN-1.
- Mid-operation reset: aborts the frame immediately and drops DV. The TX engine finishes its byte on its own.

Decomposition:
- Shared package uart_frame_pkg holds:
  - byte constants SOF0=0x53, SOF1=0x54, EOF0=0x45, EOF1=0x4E, EOF2=0x44;
  - the state enum {IDLE, SEND, WAIT, DONE};
  - FRAME_OVERHEAD=6.
- The RX parser will also import this package.
- Sub-module rr_arbiter (NUM_REQ): inputs req, pointer, enable; outputs a one-hot winner and its index. It is combinational plus the pointer register.

Test Plan:
- Single frame: NUM_REQ=2, PB=4. i_Enable=1, i_Req=01, payload0=0x11223344 LSB-first. TX byte sequence is 53 54 00 44 33 22 11 45 4E 44. o_Grant=01 pulses once; o_Frame_Done pulses once; o_Last_Id=0.
- Contention: i_Req=11 held for 4 frames -> ids 0,1,0,1 in order. Each frame has exactly 10 DV strobes, with a 1-cycle gap between frames.
- Enable gating: i_Req=10 with i_Enable=0 for 100 cycles -> no DV, o_Busy=0. Raise enable -> grant 10 on the next edge. Drop enable at byte 5 -> the frame still completes all 10 bytes, with no further grant.
- TX engine busy: hold i_TX_Active=1 for 20 cycles at grant -> o_TX_DV stays low and asserts on the first cycle after Active falls. A stray i_TX_Done while in SEND is ignored.
- Reset mid-frame: assert i_Rst_n=0 during WAIT of byte 6 -> all outputs 0 asynchronously. After release with i_Req=10, the next frame starts from 'S' with id 1, because the pointer reset to 0 and req0 is idle.
